// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RISC-V control FSM (IF/ID/EX/MEM/WB/HALT) driving datapath strobes,
// with free-running cycle and retired-instruction performance counters.
module multi_cycle_control_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             alu_bcond,
    input  logic             halt_req,
    output logic [2:0]       state,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             pc_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             pc_write,
    output logic [1:0]       pc_source,
    output logic             is_halted,
    output logic             illegal_inst,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] PC_PLUS4   = 2'b00;
    localparam logic [1:0] PC_BRANCH  = 2'b01;
    localparam logic [1:0] PC_JUMP    = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cycle_count_q;
    logic [CNT_W-1:0] cycle_count_d;
    logic [CNT_W-1:0] retired_count_q;
    logic [CNT_W-1:0] retired_count_d;
    logic             halt_entry_s;

    // Next-state and control-strobe decode; everything defaults to inactive
    always_comb begin
        state_d      = state_q;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        i_or_d       = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        pc_to_reg    = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRC_B_RS2;
        alu_op       = ALU_ADD;
        pc_write     = 1'b0;
        pc_source    = PC_PLUS4;
        is_halted    = 1'b0;
        illegal_inst = 1'b0;
        halt_entry_s = 1'b0;
        case (state_q)
            ST_IF: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = ST_ID;
                end else begin
                    state_d  = ST_IF;
                end
            end
            ST_ID: begin
                state_d = ST_EX;
            end
            ST_EX: begin
                case (opcode)
                    OP_ARITH: begin
                        alu_op  = ALU_FUNCT;
                        state_d = ST_WB;
                    end
                    OP_ARITH_IMM: begin
                        alu_src_b = SRC_B_IMM;
                        alu_op    = ALU_FUNCT;
                        state_d   = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b = SRC_B_IMM;
                        state_d   = ST_MEM;
                    end
                    OP_BRANCH: begin
                        alu_op    = ALU_BRANCH;
                        pc_write  = 1'b1;
                        pc_source = alu_bcond ? PC_BRANCH : PC_PLUS4;
                        state_d   = ST_IF;
                    end
                    OP_JAL: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRC_B_IMM;
                        state_d   = ST_WB;
                    end
                    OP_JALR: begin
                        alu_src_b = SRC_B_IMM;
                        state_d   = ST_WB;
                    end
                    OP_ECALL: begin
                        if (halt_req) begin
                            halt_entry_s = 1'b1;
                            state_d      = ST_HALT;
                        end else begin
                            pc_write = 1'b1;
                            state_d  = ST_IF;
                        end
                    end
                    default: begin
                        illegal_inst = 1'b1;
                        pc_write     = 1'b1;
                        state_d      = ST_IF;
                    end
                endcase
            end
            ST_MEM: begin
                i_or_d = 1'b1;
                if (opcode == OP_LOAD) begin
                    mem_read = 1'b1;
                    state_d  = mem_ready ? ST_WB : ST_MEM;
                end else if (opcode == OP_STORE) begin
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        pc_write = 1'b1;
                        state_d  = ST_IF;
                    end else begin
                        state_d  = ST_MEM;
                    end
                end else begin
                    // Opcode changed under us: drop the access and refetch
                    i_or_d  = 1'b0;
                    state_d = ST_IF;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = ST_IF;
                if (opcode == OP_LOAD) begin
                    mem_to_reg = 1'b1;
                end else if ((opcode == OP_JAL) || (opcode == OP_JALR)) begin
                    pc_to_reg = 1'b1;
                    pc_source = PC_JUMP;
                end else begin
                    pc_source = PC_PLUS4;
                end
            end
            ST_HALT: begin
                is_halted = 1'b1;
                state_d   = ST_HALT;
            end
            default: begin
                state_d = ST_IF;
            end
        endcase
    end

    // Performance counter next values: instructions retire on their PC update or on halting
    always_comb begin
        cycle_count_d   = cycle_count_q;
        retired_count_d = retired_count_q;
        if (state_q != ST_HALT) begin
            cycle_count_d = cycle_count_q + CNT_ONE;
        end else begin
            cycle_count_d = cycle_count_q;
        end
        if (pc_write || halt_entry_s) begin
            retired_count_d = retired_count_q + CNT_ONE;
        end else begin
            retired_count_d = retired_count_q;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IF;
            cycle_count_q   <= {CNT_W{1'b0}};
            retired_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q         <= state_d;
            cycle_count_q   <= cycle_count_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign state         = state_q;
    assign cycle_count   = cycle_count_q;
    assign retired_count = retired_count_q;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Self-checking bench: directed instruction table, halt/reset corner sequences and
// randomized instruction streams checked cycle by cycle against an instruction-level model.
module tb_multi_cycle_control_unit;

    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       is_halted;
        logic       illegal_inst;
    } ctl_t;

    typedef struct {
        logic [6:0] op;
        logic       bc;
        logic       hr;
        int         if_wait;
        int         mem_wait;
        int         exp_cycles;
        int         exp_retired;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        alu_bcond;
    logic        halt_req;
    logic [2:0]  state;
    logic        mem_read, mem_write, i_or_d, ir_write;
    logic        reg_write, mem_to_reg, pc_to_reg, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic        pc_write, is_halted, illegal_inst;
    logic [31:0] cycle_count, retired_count;
    ctl_t        act;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] cyc_m;
    logic [31:0] ret_m;

    multi_cycle_control_unit #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .alu_bcond(alu_bcond), .halt_req(halt_req), .state(state),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_write(pc_write), .pc_source(pc_source), .is_halted(is_halted),
        .illegal_inst(illegal_inst), .cycle_count(cycle_count), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    assign act = {mem_read, mem_write, i_or_d, ir_write, reg_write, mem_to_reg, pc_to_reg,
                  alu_src_a, alu_src_b, alu_op, pc_write, pc_source, is_halted, illegal_inst};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_total++;
        if (act_v === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act_v, exp_v);
        end
    endtask

    function automatic logic rnd_bit();
        return ($urandom_range(0, 1) == 1);
    endfunction

    // One clock: drive mem_ready, check state/controls mid-cycle, then advance the model counters
    task automatic cyc(input logic [2:0] es, input logic mr, input ctl_t e,
                       input logic enter_halt, input string tag);
        mem_ready = mr;
        @(negedge clk);
        chk({tag, " state"}, 64'(state), 64'(es));
        chk({tag, " controls"}, 64'(act), 64'(e));
        @(posedge clk);
        #1;
        if (es != 3'd5) cyc_m = cyc_m + 32'd1;
        if (e.pc_write || enter_halt) ret_m = ret_m + 32'd1;
    endtask

    // Runs one instruction from its first IF cycle, following the expected phase sequence
    task automatic run_instr(input logic [6:0] op, input logic bc, input logic hr,
                             input int if_wait, input int mem_wait, output logic halted);
        ctl_t e_if, e_id, e_ex, e_mem, e_wb;
        logic is_ld, is_st, is_jmp, to_wb, to_mem;
        e_if = '0; e_id = '0; e_ex = '0; e_mem = '0; e_wb = '0;
        opcode = op; alu_bcond = bc; halt_req = hr;
        is_ld  = (op == OP_LOAD);
        is_st  = (op == OP_STORE);
        is_jmp = (op == OP_JAL) || (op == OP_JALR);
        to_wb  = 1'b0;
        to_mem = 1'b0;
        halted = 1'b0;
        chk("cycle_count at fetch", 64'(cycle_count), 64'(cyc_m));
        chk("retired_count at fetch", 64'(retired_count), 64'(ret_m));
        e_if.mem_read = 1'b1;
        for (int i = 0; i < if_wait; i++) cyc(3'd0, 1'b0, e_if, 1'b0, "IF wait");
        e_if.ir_write = 1'b1;
        cyc(3'd0, 1'b1, e_if, 1'b0, "IF");
        cyc(3'd1, rnd_bit(), e_id, 1'b0, "ID");
        case (op)
            OP_ARITH:     begin e_ex.alu_op = 2'b10; to_wb = 1'b1; end
            OP_ARITH_IMM: begin e_ex.alu_src_b = 2'b01; e_ex.alu_op = 2'b10; to_wb = 1'b1; end
            OP_LOAD:      begin e_ex.alu_src_b = 2'b01; to_mem = 1'b1; end
            OP_STORE:     begin e_ex.alu_src_b = 2'b01; to_mem = 1'b1; end
            OP_BRANCH:    begin e_ex.alu_op = 2'b01; e_ex.pc_write = 1'b1; e_ex.pc_source = {1'b0, bc}; end
            OP_JAL:       begin e_ex.alu_src_a = 1'b1; e_ex.alu_src_b = 2'b01; to_wb = 1'b1; end
            OP_JALR:      begin e_ex.alu_src_b = 2'b01; to_wb = 1'b1; end
            OP_ECALL:     begin e_ex.pc_write = !hr; halted = hr; end
            default:      begin e_ex.illegal_inst = 1'b1; e_ex.pc_write = 1'b1; end
        endcase
        cyc(3'd2, rnd_bit(), e_ex, halted, "EX");
        if (to_mem) begin
            e_mem.i_or_d    = 1'b1;
            e_mem.mem_read  = is_ld;
            e_mem.mem_write = is_st;
            for (int i = 0; i < mem_wait; i++) cyc(3'd3, 1'b0, e_mem, 1'b0, "MEM wait");
            e_mem.pc_write = is_st;
            cyc(3'd3, 1'b1, e_mem, 1'b0, "MEM");
            to_wb = is_ld;
        end
        if (to_wb) begin
            e_wb.reg_write  = 1'b1;
            e_wb.pc_write   = 1'b1;
            e_wb.mem_to_reg = is_ld;
            e_wb.pc_to_reg  = is_jmp;
            e_wb.pc_source  = is_jmp ? 2'b10 : 2'b00;
            cyc(3'd4, rnd_bit(), e_wb, 1'b0, "WB");
        end
    endtask

    task automatic halt_hold();
        ctl_t e_h;
        e_h = '0;
        e_h.is_halted = 1'b1;
        for (int i = 0; i < 10; i++) begin
            opcode   = 7'($urandom);
            halt_req = rnd_bit();
            cyc(3'd5, rnd_bit(), e_h, 1'b0, "HALT");
        end
        chk("cycle_count frozen in HALT", 64'(cycle_count), 64'(cyc_m));
        chk("retired_count frozen in HALT", 64'(retired_count), 64'(ret_m));
    endtask

    // Asynchronous reset pulse starting between edges; returns aligned just after a rising edge
    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("reset state", 64'(state), 64'd0);
        chk("reset cycle_count", 64'(cycle_count), 64'd0);
        chk("reset retired_count", 64'(retired_count), 64'd0);
        chk("reset is_halted", 64'(is_halted), 64'd0);
        chk("reset illegal_inst", 64'(illegal_inst), 64'd0);
        chk("reset mem_write", 64'(mem_write), 64'd0);
        chk("reset i_or_d", 64'(i_or_d), 64'd0);
        cyc_m = 32'd0;
        ret_m = 32'd0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        vec_t        vt [12];
        logic [6:0]  pool [8];
        logic        h;
        logic [31:0] base_c;
        logic [31:0] base_r;
        ctl_t        e_a;
        ctl_t        e_b;
        int          sel;

        vt[0]  = '{OP_ARITH,     1'b0, 1'b0, 0, 0, 4, 1};
        vt[1]  = '{OP_ARITH_IMM, 1'b0, 1'b0, 1, 0, 5, 1};
        vt[2]  = '{OP_LOAD,      1'b0, 1'b0, 0, 3, 8, 1};
        vt[3]  = '{OP_STORE,     1'b0, 1'b0, 0, 1, 5, 1};
        vt[4]  = '{OP_BRANCH,    1'b1, 1'b0, 0, 0, 3, 1};
        vt[5]  = '{OP_BRANCH,    1'b0, 1'b0, 0, 0, 3, 1};
        vt[6]  = '{OP_JAL,       1'b0, 1'b0, 2, 0, 6, 1};
        vt[7]  = '{OP_JALR,      1'b1, 1'b0, 0, 0, 4, 1};
        vt[8]  = '{OP_ECALL,     1'b0, 1'b0, 0, 0, 3, 1};
        vt[9]  = '{7'b0000000,   1'b0, 1'b0, 0, 0, 3, 1};
        vt[10] = '{7'b1111111,   1'b0, 1'b1, 0, 0, 3, 1};
        vt[11] = '{7'b0000001,   1'b1, 1'b0, 1, 0, 4, 1};
        pool[0] = OP_JAL;    pool[1] = OP_JALR;      pool[2] = OP_BRANCH; pool[3] = OP_LOAD;
        pool[4] = OP_STORE;  pool[5] = OP_ARITH_IMM; pool[6] = OP_ARITH;  pool[7] = OP_ECALL;

        reset = 1'b0; opcode = 7'd0; mem_ready = 1'b0; alu_bcond = 1'b0; halt_req = 1'b0;
        cyc_m = 32'd0; ret_m = 32'd0;
        #3;
        chk("power-on state", 64'(state), 64'd0);
        chk("power-on cycle_count", 64'(cycle_count), 64'd0);
        chk("power-on retired_count", 64'(retired_count), 64'd0);
        chk("power-on is_halted", 64'(is_halted), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int r = 0; r < 12; r++) begin
            base_c = cyc_m;
            base_r = ret_m;
            run_instr(vt[r].op, vt[r].bc, vt[r].hr, vt[r].if_wait, vt[r].mem_wait, h);
            chk($sformatf("row %0d cycles", r), 64'(cycle_count), 64'(base_c + 32'(vt[r].exp_cycles)));
            chk($sformatf("row %0d retired", r), 64'(retired_count), 64'(base_r + 32'(vt[r].exp_retired)));
        end

        base_c = cyc_m;
        base_r = ret_m;
        run_instr(OP_ECALL, 1'b0, 1'b1, 0, 0, h);
        chk("ECALL halt cycles", 64'(cycle_count), 64'(base_c + 32'd3));
        chk("ECALL halt retired", 64'(retired_count), 64'(base_r + 32'd1));
        halt_hold();
        do_reset();

        // Reset landing in the middle of a stalled store access
        e_a = '0;
        e_b = '0;
        opcode = OP_STORE;
        e_a.mem_read = 1'b1;
        e_a.ir_write = 1'b1;
        cyc(3'd0, 1'b1, e_a, 1'b0, "SW IF");
        cyc(3'd1, 1'b0, e_b, 1'b0, "SW ID");
        e_b.alu_src_b = 2'b01;
        cyc(3'd2, 1'b0, e_b, 1'b0, "SW EX");
        e_b = '0;
        e_b.i_or_d = 1'b1;
        e_b.mem_write = 1'b1;
        cyc(3'd3, 1'b0, e_b, 1'b0, "SW MEM wait");
        mem_ready = 1'b0;
        #1;
        chk("SW mem_write before reset", 64'(mem_write), 64'd1);
        do_reset();

        for (int k = 0; k < 200; k++) begin
            sel = $urandom_range(0, 9);
            run_instr((sel < 8) ? pool[sel] : 7'($urandom), rnd_bit(),
                      ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 4), h);
            if (h) begin
                halt_hold();
                do_reset();
            end
        end
        chk("final cycle_count", 64'(cycle_count), 64'(cyc_m));
        chk("final retired_count", 64'(retired_count), 64'(ret_m));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control_unit.md
MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of both performance counters.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port opcode  input  7  inst[6:0] from the external instruction register, stable from ID onward.
REQ-005 SHALL have port mem_ready  input  1  memory done: read data valid or write accepted this cycle.
REQ-006 SHALL have port alu_bcond  input  1  branch-taken result from the ALU, valid in EX.
REQ-007 SHALL have port halt_req  input  1  ECALL halt condition (x17 == 10), valid in EX.
REQ-008 SHALL have port state  output  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
REQ-009 SHALL have port mem_read, mem_write, i_or_d, ir_write  output  1 each  memory controls; i_or_d 0 = PC address, 1 = ALU result.
REQ-010 SHALL have port reg_write, mem_to_reg, pc_to_reg  output  1 each  register-file write controls.
REQ-011 SHALL have port alu_src_a  output  1  0 = rs1, 1 = PC.
REQ-012 SHALL have port alu_src_b  output  2  00 = rs2, 01 = immediate, 10 = constant 4.
REQ-013 SHALL have port alu_op  output  2  00 = add, 01 = branch compare, 10 = funct decode.
REQ-014 SHALL have port pc_write, pc_source  output  1, 2  PC update strobe; source 00 = PC+4, 01 = branch target, 10 = jump target (ALU out).
REQ-015 SHALL have port is_halted, illegal_inst  output  1 each  halt level; one-cycle illegal-opcode pulse.
REQ-016 SHALL have port cycle_count, retired_count  output  CNT_W each  performance counters.

Function
REQ-017 SHALL decode opcodes JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, ARITH_IMM 0010011, ARITH 0110011, ECALL 1110011; any other value is illegal.
REQ-018 SHALL drive every control output to 0 in any state or cycle not listed below.
REQ-019 IF SHALL assert mem_read with i_or_d=0, and SHALL assert ir_write and go to ID only in a cycle with mem_ready=1; otherwise it holds IF.
REQ-020 ID SHALL last exactly one cycle and always go to EX.
REQ-021 EX SHALL drive the ALU as follows: ARITH a=0,b=00,op=10; ARITH_IMM a=0,b=01,op=10; LOAD/STORE a=0,b=01,op=00; BRANCH a=0,b=00,op=01; JAL a=1,b=01,op=00; JALR a=0,b=01,op=00.
REQ-022 EX transitions SHALL be: ARITH, ARITH_IMM, JAL, JALR -> WB; LOAD, STORE -> MEM; BRANCH -> IF.
REQ-023 For BRANCH, EX SHALL assert pc_write, with pc_source=01 if alu_bcond=1 and 00 otherwise.
REQ-024 For ECALL, EX SHALL go to HALT if halt_req=1; otherwise it SHALL assert pc_write with pc_source=00 and go to IF.
REQ-025 For an illegal opcode, EX SHALL pulse illegal_inst for one cycle, assert pc_write with pc_source=00, and go to IF.
REQ-026 MEM SHALL assert i_or_d=1 plus mem_read (LOAD) or mem_write (STORE), holding while mem_ready=0.
REQ-027 On mem_ready=1 in MEM, LOAD SHALL go to WB, and STORE SHALL assert pc_write with pc_source=00 and go to IF.
REQ-028 WB SHALL assert reg_write and pc_write and go to IF.
REQ-029 In WB, LOAD SHALL set mem_to_reg=1 and pc_source=00; JAL/JALR SHALL set pc_to_reg=1 and pc_source=10; ARITH/ARITH_IMM SHALL set pc_source=00.
REQ-030 HALT SHALL hold is_halted=1 and all other controls at 0, and is exited only by reset.
REQ-031 cycle_count SHALL increment by 1 in every cycle whose state is not HALT, wrapping modulo 2^CNT_W.
REQ-032 retired_count SHALL increment once per instruction, on its pc_write cycle or on entry to HALT, wrapping modulo 2^CNT_W.
REQ-033 mem_read and mem_write SHALL never both be 1; reg_write and mem_write SHALL never both be 1.

Reset
REQ-034 Asserting reset (0) SHALL immediately, without a clock, force state=IF, cycle_count=0, retired_count=0, is_halted=0, illegal_inst=0.
REQ-035 Reset SHALL take effect from any state, including mid-MEM or HALT; no memory strobe from the aborted instruction remains asserted.
REQ-036 After reset deasserts, the first rising edge SHALL evaluate IF normally.

Verification
REQ-037 ADD (0110011), mem_ready=1 -> IF,ID,EX,WB,IF; reg_write only in WB; retired_count=1 and cycle_count=4 at re-entry to IF.
REQ-038 LW, mem_ready=0 for 3 MEM cycles -> MEM held 4 cycles with mem_read=1 and i_or_d=1, then WB with mem_to_reg=1; retired_count=1 after 8 cycles.
REQ-039 BEQ with alu_bcond=1 -> EX pc_write=1, pc_source=01; BEQ with alu_bcond=0 -> pc_source=00; 3 cycles each.
REQ-040 ECALL, halt_req=1 -> HALT, is_halted=1, counters frozen for 10 cycles; ECALL, halt_req=0 -> IF after EX with retired_count +1.
REQ-041 opcode 0000000 -> illegal_inst=1 for exactly one cycle in EX, with pc_write=1 and pc_source=00, then IF.
REQ-042 reset driven to 0 during MEM of SW -> state=0 and mem_write=0 immediately, both counters 0.
